// File: rtl/sp_fetch_pkg.sv
// Shared types for the sprite-ROM fetch responder (sp_fetch_responder, sp_pf_buf).
// The prefetch path is compiled in with SP_FETCH_PREFETCH_EN.
package sp_fetch_pkg;

    localparam int unsigned AW_DEF  = 16;
    localparam int unsigned MAW_DEF = 23;
    localparam int unsigned DW      = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        PF   = 2'd2
    } state_t;

    typedef logic client_t;

    localparam client_t CL_SP1 = 1'b0;
    localparam client_t CL_SP2 = 1'b1;

endpackage

// File: rtl/sp_pf_buf.sv
// One-entry prefetch buffer {valid, addr, data} for a single client.
// Only instantiated when SP_FETCH_PREFETCH_EN is defined; invalidate wins over fill.
module sp_pf_buf
    import sp_fetch_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [DW-1:0] fill_data,
    input  logic          inv,
    input  logic [AW-1:0] look_addr,
    output logic          hit_c,
    output logic [DW-1:0] data
);

    logic          valid;
    logic [AW-1:0] addr;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (inv) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            addr  <= fill_addr;
            data  <= fill_data;
        end
    end

    assign hit_c = valid && (addr == look_addr);

endmodule

// File: rtl/sp_fetch_responder.sv
// Toggle req/ack responder arbitrating two sprite clients onto one single-outstanding read port.
// Define SP_FETCH_PREFETCH_EN to add next-word prefetch with one buffer per client.
module sp_fetch_responder
    import sp_fetch_pkg::*;
#(
    parameter int unsigned    AW       = AW_DEF,
    parameter int unsigned    MAW      = MAW_DEF,
    parameter logic [MAW-1:0] SP1_BASE = MAW'(23'h0),
    parameter logic [MAW-1:0] SP2_BASE = MAW'(23'h10000)
) (
    input  logic           clk_sys,
    input  logic           reset,
    input  logic           dl_busy,
    input  logic           sp1_req,
    input  logic [AW-1:0]  sp1_addr,
    output logic           sp1_ack,
    output logic [DW-1:0]  sp1_q,
    input  logic           sp2_req,
    input  logic [AW-1:0]  sp2_addr,
    output logic           sp2_ack,
    output logic [DW-1:0]  sp2_q,
    output logic           mem_req,
    output logic [MAW-1:0] mem_addr,
    input  logic           mem_rdy,
    input  logic [DW-1:0]  mem_q
);

    state_t         state;
    client_t        cur;
    client_t        rr_last;

    logic           pend1;
    logic           pend2;
    client_t        gnt;
    logic [AW-1:0]  gnt_addr;
    logic [MAW-1:0] gnt_base;
    logic           hit_take;
    logic [DW-1:0]  hit_data;
    logic           dlv;
    client_t        dlv_cl;
    logic [DW-1:0]  dlv_data;

`ifdef SP_FETCH_PREFETCH_EN
    logic [AW-1:0]  cur_addr;
    logic [AW-1:0]  pf_addr;
    logic [MAW-1:0] cur_base;
    logic           pend_other;
    logic           hit1_c;
    logic           hit2_c;
    logic [DW-1:0]  data1;
    logic [DW-1:0]  data2;
    logic           inv1;
    logic           inv2;
    logic           fill1;
    logic           fill2;

    sp_pf_buf #(.AW(AW)) u_buf1 (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .fill      (fill1),
        .fill_addr (cur_addr),
        .fill_data (mem_q),
        .inv       (inv1),
        .look_addr (sp1_addr),
        .hit_c     (hit1_c),
        .data      (data1)
    );

    sp_pf_buf #(.AW(AW)) u_buf2 (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .fill      (fill2),
        .fill_addr (cur_addr),
        .fill_data (mem_q),
        .inv       (inv2),
        .look_addr (sp2_addr),
        .hit_c     (hit2_c),
        .data      (data2)
    );
`endif

    // Arbitration, buffer hit detection and the delivery strobe shared by reads and hits
    always_comb begin
        pend1 = sp1_req != sp1_ack;
        pend2 = sp2_req != sp2_ack;
        gnt   = CL_SP1;
        if (pend1 && pend2) begin
            gnt = (rr_last == CL_SP1) ? CL_SP2 : CL_SP1;
        end else if (pend2) begin
            gnt = CL_SP2;
        end
        gnt_addr = (gnt == CL_SP2) ? sp2_addr : sp1_addr;
        gnt_base = (gnt == CL_SP2) ? SP2_BASE : SP1_BASE;
        hit_take = 1'b0;
        hit_data = '0;
`ifdef SP_FETCH_PREFETCH_EN
        hit_take   = (state == IDLE) && !dl_busy &&
                     ((gnt == CL_SP2) ? (pend2 && hit2_c) : (pend1 && hit1_c));
        hit_data   = (gnt == CL_SP2) ? data2 : data1;
        pf_addr    = cur_addr + AW'(1);
        cur_base   = (cur == CL_SP2) ? SP2_BASE : SP1_BASE;
        pend_other = (cur == CL_SP2) ? pend1 : pend2;
        inv1       = dl_busy || (hit_take && (gnt == CL_SP1));
        inv2       = dl_busy || (hit_take && (gnt == CL_SP2));
        fill1      = (state == PF) && mem_req && mem_rdy && (cur == CL_SP1);
        fill2      = (state == PF) && mem_req && mem_rdy && (cur == CL_SP2);
`endif
        dlv      = ((state == RD) && mem_rdy) || hit_take;
        dlv_cl   = (state == RD) ? cur : gnt;
        dlv_data = (state == RD) ? mem_q : hit_data;
    end

    // Memory-side FSM; mem_rdy is only honoured while a read is outstanding
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cur      <= CL_SP1;
            mem_req  <= 1'b0;
            mem_addr <= '0;
`ifdef SP_FETCH_PREFETCH_EN
            cur_addr <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!dl_busy && (pend1 || pend2) && !hit_take) begin
                        cur      <= gnt;
                        mem_addr <= gnt_base + MAW'(gnt_addr);
                        mem_req  <= 1'b1;
                        state    <= RD;
`ifdef SP_FETCH_PREFETCH_EN
                        cur_addr <= gnt_addr;
`endif
                    end
                end
                RD: begin
                    if (mem_rdy) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
`ifdef SP_FETCH_PREFETCH_EN
                        if (!pend_other && !dl_busy) begin
                            cur_addr <= pf_addr;
                            mem_addr <= cur_base + MAW'(pf_addr);
                            state    <= PF;
                        end
`endif
                    end
                end
`ifdef SP_FETCH_PREFETCH_EN
                // mem_req re-rises one cycle after the demand read so the memory sees a fresh request
                PF: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_rdy) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Client-side delivery: data and ack toggle always move together
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sp1_ack <= 1'b0;
            sp1_q   <= '0;
            sp2_ack <= 1'b0;
            sp2_q   <= '0;
            rr_last <= CL_SP2;
        end else if (dlv) begin
            rr_last <= dlv_cl;
            if (dlv_cl == CL_SP1) begin
                sp1_ack <= ~sp1_ack;
                sp1_q   <= dlv_data;
            end else begin
                sp2_ack <= ~sp2_ack;
                sp2_q   <= dlv_data;
            end
        end
    end

endmodule

// File: tb/tb_sp_fetch_responder.sv
// Scoreboard bench for sp_fetch_responder: expected read data is queued per client on each
// request toggle and popped on each ack toggle; SP_FETCH_PREFETCH_EN selects prefetch expectations.
module tb_sp_fetch_responder;

    localparam logic [22:0] SP1_BASE = 23'h0;
    localparam logic [22:0] SP2_BASE = 23'h7F0001;
    localparam int          MEM_LAT  = 3;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        dl_busy;
    logic        sp1_req, sp2_req;
    logic [15:0] sp1_addr, sp2_addr;
    logic        sp1_ack, sp2_ack;
    logic [15:0] sp1_q, sp2_q;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_rdy;
    logic [15:0] mem_q;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] exp_q1[$];
    logic [15:0] exp_q2[$];
    logic [22:0] mem_log[$];

    int tog_cyc, rise_cyc, rdy_cyc, ack_cyc1, ack_cyc2;
    logic        p_req, p_ack1, p_ack2;
    logic [15:0] p_q1, p_q2;
    logic [22:0] cap_addr;

    sp_fetch_responder #(
        .AW       (16),
        .MAW      (23),
        .SP1_BASE (SP1_BASE),
        .SP2_BASE (SP2_BASE)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .dl_busy  (dl_busy),
        .sp1_req  (sp1_req),
        .sp1_addr (sp1_addr),
        .sp1_ack  (sp1_ack),
        .sp1_q    (sp1_q),
        .sp2_req  (sp2_req),
        .sp2_addr (sp2_addr),
        .sp2_ack  (sp2_ack),
        .sp2_q    (sp2_q),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdy  (mem_rdy),
        .mem_q    (mem_q)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] mem_data(input logic [22:0] a);
        if (a == 23'h123) return 16'hBEEF;
        return 16'hA5C3 ^ a[15:0] ^ {9'b0, a[22:16]};
    endfunction

    function automatic logic [22:0] maddr(input logic cl, input logic [15:0] a);
        logic [22:0] s;
        s = (cl ? SP2_BASE : SP1_BASE) + {7'b0, a};
        return s;
    endfunction

    function automatic logic [22:0] log_at(input int i);
        if (i < mem_log.size()) return mem_log[i];
        return 23'h7FFFFF;
    endfunction

    // Memory model: answers a held mem_req after MEM_LAT cycles with a one-cycle strobe
    initial begin
        int lat;
        lat     = 0;
        mem_rdy = 1'b0;
        mem_q   = '0;
        forever begin
            @(posedge clk_sys);
            #1;
            mem_rdy = 1'b0;
            if (reset || !mem_req) begin
                lat = 0;
            end else if (lat == MEM_LAT) begin
                mem_rdy = 1'b1;
                mem_q   = mem_data(mem_addr);
                lat     = 0;
            end else begin
                lat++;
            end
        end
    end

    // Output monitor: logs memory requests and pops the scoreboard on each ack toggle
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (mem_req && !p_req) begin
                mem_log.push_back(mem_addr);
                rise_cyc = cyc;
                cap_addr = mem_addr;
            end
            if (mem_req && mem_rdy) begin
                rdy_cyc = cyc;
                check("mem_addr_stable", 32'(mem_addr), 32'(cap_addr));
            end
            if (sp1_ack != p_ack1) begin
                ack_cyc1 = cyc;
                if (exp_q1.size() == 0) check("sp1_spurious_ack", 32'd1, 32'd0);
                else check("sp1_q", 32'(sp1_q), 32'(exp_q1.pop_front()));
            end else if (sp1_q != p_q1) begin
                check("sp1_q_hold", 32'(sp1_q), 32'(p_q1));
            end
            if (sp2_ack != p_ack2) begin
                ack_cyc2 = cyc;
                if (exp_q2.size() == 0) check("sp2_spurious_ack", 32'd1, 32'd0);
                else check("sp2_q", 32'(sp2_q), 32'(exp_q2.pop_front()));
            end else if (sp2_q != p_q2) begin
                check("sp2_q_hold", 32'(sp2_q), 32'(p_q2));
            end
        end
        p_req  = mem_req;
        p_ack1 = sp1_ack;
        p_ack2 = sp2_ack;
        p_q1   = sp1_q;
        p_q2   = sp2_q;
    end

    task automatic send(input logic cl, input logic [15:0] a);
        if (cl) begin
            sp2_addr = a;
            sp2_req  = ~sp2_req;
            exp_q2.push_back(mem_data(maddr(1'b1, a)));
        end else begin
            sp1_addr = a;
            sp1_req  = ~sp1_req;
            exp_q1.push_back(mem_data(maddr(1'b0, a)));
        end
        tog_cyc = cyc;
    endtask

    task automatic wait_acks(input int budget);
        int i = 0;
        while ((exp_q1.size() != 0 || exp_q2.size() != 0) && i < budget) begin
            @(negedge clk_sys);
            i++;
        end
        if (exp_q1.size() != 0 || exp_q2.size() != 0) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_quiet();
        int q = 0;
        int i = 0;
        while (q < 6 && i < 300) begin
            @(negedge clk_sys);
            i++;
            q = mem_req ? 0 : q + 1;
        end
        if (q < 6) check("quiet_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_mem_req"}, 32'(mem_req), 32'd0);
        check({pfx, "_sp1_ack"}, 32'(sp1_ack), 32'd0);
        check({pfx, "_sp2_ack"}, 32'(sp2_ack), 32'd0);
        check({pfx, "_sp1_q"},   32'(sp1_q),   32'd0);
        check({pfx, "_sp2_q"},   32'(sp2_q),   32'd0);
    endtask

    initial begin
        int n0;
        int t;
        reset    = 1'b1;
        dl_busy  = 1'b0;
        sp1_req  = 1'b0;
        sp2_req  = 1'b0;
        sp1_addr = '0;
        sp2_addr = '0;
        repeat (3) @(negedge clk_sys);
        check_reset_state("rst");
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        #2 reset = 1'b0;

        // Single request with known data and latency
        @(negedge clk_sys);
        n0 = mem_log.size();
        send(1'b0, 16'h0123);
        wait_acks(50);
        check("t1_req_lat",  32'(rise_cyc - tog_cyc), 32'd1);
        check("t1_mem_addr", 32'(log_at(n0)), 32'h123);
        check("t1_ack_lat",  32'(ack_cyc1 - rdy_cyc), 32'd1);
        check("t1_sp1_q",    32'(sp1_q), 32'hBEEF);
        wait_quiet();

        // Address wrap on client 2; also leaves rr_last = client 2
        @(negedge clk_sys);
        n0 = mem_log.size();
        send(1'b1, 16'hFFFF);
        wait_acks(50);
        check("t3_mem_addr", 32'(log_at(n0)), 32'h0);
        check("t3_sp2_q",    32'(sp2_q), 32'(mem_data(23'h0)));
        wait_quiet();

        // Simultaneous requests: client 1 wins because client 2 was served last
        @(negedge clk_sys);
        n0 = mem_log.size();
        send(1'b0, 16'h0200);
        send(1'b1, 16'h0300);
        wait_acks(100);
        wait_quiet();
        check("t2_first",  32'(log_at(n0)),     32'(maddr(1'b0, 16'h0200)));
        check("t2_second", 32'(log_at(n0 + 1)), 32'(maddr(1'b1, 16'h0300)));
        check("t2_order",  32'(ack_cyc1 < ack_cyc2), 32'd1);
`ifdef SP_FETCH_PREFETCH_EN
        check("t2_pulses", 32'(mem_log.size() - n0), 32'd3);
        check("t2_pf",     32'(log_at(n0 + 2)), 32'(maddr(1'b1, 16'h0301)));
`else
        check("t2_pulses", 32'(mem_log.size() - n0), 32'd2);
`endif

        // Download busy: request waits, and any prefetched 0x124 must not be used
        @(negedge clk_sys);
        n0 = mem_log.size();
        dl_busy = 1'b1;
        @(negedge clk_sys);
        send(1'b0, 16'h0124);
        repeat (6) @(negedge clk_sys);
        check("t4_busy_hold", 32'(mem_log.size() - n0), 32'd0);
        check("t4_no_ack",    32'(exp_q1.size()), 32'd1);
        dl_busy = 1'b0;
        t = cyc;
        wait_acks(50);
        check("t4_count",  32'(mem_log.size() - n0), 32'd1);
        check("t4_addr",   32'(log_at(n0)), 32'(maddr(1'b0, 16'h0124)));
        check("t4_resume", 32'((rise_cyc - t) <= 2), 32'd1);
        wait_quiet();

        // Reset while a read is outstanding, then a fresh request
        @(negedge clk_sys);
        send(1'b1, 16'h0040);
        t = 0;
        while (!mem_req && t < 20) begin
            @(negedge clk_sys);
            t++;
        end
        check("t5_in_rd", 32'(mem_req), 32'd1);
        @(negedge clk_sys);
        #2 reset = 1'b1;
        #1;
        check_reset_state("t5");
        sp1_req = 1'b0;
        sp2_req = 1'b0;
        exp_q1.delete();
        exp_q2.delete();
        repeat (2) @(negedge clk_sys);
        #2 reset = 1'b0;
        @(negedge clk_sys);
        send(1'b0, 16'h0050);
        wait_acks(50);
        check("t5_after", 32'(sp1_q), 32'(mem_data(maddr(1'b0, 16'h0050))));
        wait_quiet();

        // Sequential reads 0x10, 0x11 then 0x20
        @(negedge clk_sys);
        send(1'b0, 16'h0010);
        wait_acks(50);
        wait_quiet();
        n0 = mem_log.size();
        @(negedge clk_sys);
        send(1'b0, 16'h0011);
        wait_acks(50);
        wait_quiet();
`ifdef SP_FETCH_PREFETCH_EN
        check("t6_hit_lat", 32'(ack_cyc1 - tog_cyc), 32'd1);
        check("t6_no_mem",  32'(mem_log.size() - n0), 32'd0);
`else
        check("t6_rd_count", 32'(mem_log.size() - n0), 32'd1);
        check("t6_rd_addr",  32'(log_at(n0)), 32'(maddr(1'b0, 16'h0011)));
`endif
        check("t6_sp1_q", 32'(sp1_q), 32'(mem_data(maddr(1'b0, 16'h0011))));
        n0 = mem_log.size();
        @(negedge clk_sys);
        send(1'b0, 16'h0020);
        wait_acks(50);
        check("t6_miss", 32'(log_at(n0)), 32'(maddr(1'b0, 16'h0020)));
        wait_quiet();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
